// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-code producers and consumers: state enum,
// index-width helper, canonical code generator and popcount.
package johnson_pkg;

    // Upper bound on code width handled by the helper functions.
    localparam int unsigned MaxWidth = 32;

    typedef enum logic [0:0] {
        StHunt,
        StLocked
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

    // Index k in 0..2n-1: low k ones for k <= n, otherwise the top 2n-k ones.
    function automatic logic [MaxWidth-1:0] canon_code(input int unsigned k,
                                                       input int unsigned n);
        logic [MaxWidth-1:0] code;
        code = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < n) begin
                if (k <= n) begin
                    code[i] = (i < k);
                end else begin
                    code[i] = (i >= k - n);
                end
            end
        end
        return code;
    endfunction

    function automatic int unsigned popcount(input logic [MaxWidth-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            cnt = cnt + {31'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-code decoder: maps a code word to its phase index and
// flags whether the word is one of the 2*WIDTH legal codes.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IW = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] din_i,
    output logic [IW-1:0]    k_o,
    output logic             legal_o
);

    logic [MaxWidth-1:0] din_ext;
    logic [MaxWidth-1:0] canon;
    int unsigned         p;
    int unsigned         k;

    always_comb begin
        din_ext              = '0;
        din_ext[WIDTH-1:0]   = din_i;
        p                    = popcount(din_ext);
        // MSB set means we are in the draining half of the sequence.
        k                    = din_i[WIDTH-1] ? (2 * WIDTH - p) : p;
        canon                = canon_code(k, WIDTH);
        k_o                  = IW'(k);
        legal_o              = (canon == din_ext);
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: registers the incoming bus, decodes it to a phase
// index and tracks lock on a clean, advancing sequence with error counting.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned ERR_LIMIT  = 2,
    localparam int unsigned IW        = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [IW-1:0]    idx_o,
    output logic             idx_valid_o,
    output logic             legal_o,
    output logic             locked_o,
    output logic             seq_err_o,
    output logic [7:0]       err_cnt_o
);

    localparam logic [3:0]    LockCount4 = 4'(LOCK_COUNT);
    localparam logic [3:0]    ErrLimit4  = 4'(ERR_LIMIT);
    localparam logic [IW-1:0] LastIdx    = IW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] din_q;
    logic             din_valid_q;

    state_e           state_q, state_d;
    logic [IW-1:0]    ref_q, ref_d;
    logic             ref_valid_q, ref_valid_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       bad_q, bad_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             legal_q, legal_d;
    logic             seq_err_q, seq_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [IW-1:0]    dec_k;
    logic             dec_legal;
    logic [IW-1:0]    succ;
    logic             good;
    logic [3:0]       run_inc;
    logic [3:0]       bad_inc;

    johnson_code_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .din_i   (din_q),
        .k_o     (dec_k),
        .legal_o (dec_legal)
    );

    assign succ    = (ref_q == LastIdx) ? '0 : ref_q + IW'(1);
    assign good    = dec_legal & ref_valid_q & (dec_k == succ);
    assign run_inc = run_q + 4'd1;
    assign bad_inc = bad_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        run_d       = run_q;
        bad_d       = bad_q;
        idx_d       = idx_q;
        legal_d     = legal_q;
        err_cnt_d   = err_cnt_q;
        seq_err_d   = 1'b0;
        idx_valid_d = din_valid_q & dec_legal;

        if (din_valid_q) begin
            legal_d = dec_legal;
            if (dec_legal) begin
                idx_d = dec_k;
            end
            unique case (state_q)
                StHunt: begin
                    if (dec_legal) begin
                        ref_d       = dec_k;
                        ref_valid_d = 1'b1;
                        if (good) begin
                            if (run_inc == LockCount4) begin
                                state_d = StLocked;
                                run_d   = '0;
                                bad_d   = '0;
                            end else begin
                                run_d = run_inc;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end else begin
                        // Next legal sample may only re-establish the reference.
                        run_d       = '0;
                        ref_valid_d = 1'b0;
                    end
                end
                StLocked: begin
                    if (good) begin
                        ref_d = dec_k;
                        bad_d = '0;
                    end else begin
                        seq_err_d = 1'b1;
                        if (err_cnt_q != 8'hff) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (dec_legal) begin
                            ref_d = dec_k;
                        end
                        if (bad_inc == ErrLimit4) begin
                            state_d = StHunt;
                            run_d   = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q       <= '0;
            din_valid_q <= 1'b0;
            state_q     <= StHunt;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            run_q       <= '0;
            bad_q       <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            legal_q     <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            din_q       <= din_i;
            din_valid_q <= din_valid_i;
            state_q     <= state_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            run_q       <= run_d;
            bad_q       <= bad_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            legal_q     <= legal_d;
            seq_err_q   <= seq_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign idx_o       = idx_q;
    assign idx_valid_o = idx_valid_q;
    assign legal_o     = legal_q;
    assign locked_o    = (state_q == StLocked);
    assign seq_err_o   = seq_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (WIDTH=4, LOCK_COUNT=3, ERR_LIMIT=2).
// Outputs trail the driven sample by one drive() call.
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic [3:0] din;
    logic [2:0] idx;
    logic       idx_valid;
    logic       legal;
    logic       locked;
    logic       seq_err;
    logic [7:0] err_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [3:0] codes [8];

    always #5 clk = ~clk;

    johnson_decoder #(
        .WIDTH      (4),
        .LOCK_COUNT (3),
        .ERR_LIMIT  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid_i (din_valid),
        .din_i       (din),
        .idx_o       (idx),
        .idx_valid_o (idx_valid),
        .legal_o     (legal),
        .locked_o    (locked),
        .seq_err_o   (seq_err),
        .err_cnt_o   (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_idx, input logic e_iv,
                              input logic e_legal, input logic e_lock, input logic e_serr,
                              input logic [7:0] e_cnt);
        check_eq({tag, ".idx"},       32'(idx),       32'(e_idx));
        check_eq({tag, ".idx_valid"}, 32'(idx_valid), 32'(e_iv));
        check_eq({tag, ".legal"},     32'(legal),     32'(e_legal));
        check_eq({tag, ".locked"},    32'(locked),    32'(e_lock));
        check_eq({tag, ".seq_err"},   32'(seq_err),   32'(e_serr));
        check_eq({tag, ".err_cnt"},   32'(err_cnt),   32'(e_cnt));
    endtask

    task automatic drive(input logic v, input logic [3:0] c);
        din_valid = v;
        din       = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned k;
        codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

        // Reset for two cycles with a live sample on the bus.
        rst = 1'b1;
        drive(1'b1, 4'b0111);
        drive(1'b1, 4'b1010);
        check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;

        // Acquire lock: 0000 sets ref, three good steps follow.
        drive(1'b1, codes[0]);
        check_outs("post_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(1'b1, codes[1]);
        check_outs("lock_s0", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b1, codes[2]);
        check_outs("lock_s1", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b1, codes[3]);
        check_outs("lock_s2", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

        // Advance through the wrap at full rate.
        drive(1'b1, codes[4]);
        check_outs("lock_s3", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        drive(1'b1, codes[5]);
        check_outs("wrap_4", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        drive(1'b1, codes[6]);
        check_outs("wrap_5", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        drive(1'b1, codes[7]);
        check_outs("wrap_6", 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        drive(1'b1, codes[0]);
        check_outs("wrap_7", 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        drive(1'b1, codes[1]);
        check_outs("wrap_0", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        drive(1'b0, 4'b0000);
        check_outs("wrap_1", 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

        // Illegal code while locked, then resume with the successor.
        drive(1'b1, 4'b0101);
        check_outs("idle", 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        drive(1'b1, codes[2]);
        check_outs("illegal", 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);

        // Repeated code twice drops lock.
        drive(1'b1, codes[2]);
        check_outs("resume", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        drive(1'b1, codes[2]);
        check_outs("repeat1", 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2);
        drive(1'b1, codes[3]);
        check_outs("repeat2", 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
        drive(1'b1, codes[4]);
        check_outs("relock1", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        drive(1'b1, codes[5]);
        check_outs("relock2", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        drive(1'b0, 4'b1010);
        check_outs("relock3", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);

        // Invalid cycles with garbage on the bus change nothing.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'($urandom_range(0, 15)));
            check_outs("gated", 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
        end

        // Reset while locked discards the in-flight sample.
        rst = 1'b1;
        drive(1'b1, codes[6]);
        check_outs("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        drive(1'b1, codes[0]);
        check_outs("after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // In HUNT an illegal sample clears progress; errors are not counted.
        drive(1'b1, codes[1]);
        check_outs("hunt_s0", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b1, 4'b1010);
        check_outs("hunt_s1", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b1, codes[3]);
        check_outs("hunt_ill", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(1'b1, codes[4]);
        check_outs("hunt_ref", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b1, codes[5]);
        check_outs("hunt_g1", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b1, codes[6]);
        check_outs("hunt_g2", 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 4'b0000);
        check_outs("hunt_g3", 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

        // Saturation: each round adds two errors, loses and regains lock.
        k = 6;
        for (int r = 1; r <= 130; r++) begin
            drive(1'b1, codes[k]);
            drive(1'b1, codes[k]);
            for (int s = 0; s < 3; s++) begin
                k = (k + 1) % 8;
                drive(1'b1, codes[k]);
            end
            drive(1'b0, 4'b0000);
            if (r == 1 || r == 64 || r == 128) begin
                check_eq("sat_cnt", 32'(err_cnt), (2 * r > 255) ? 32'd255 : 32'(2 * r));
                check_eq("sat_lock", 32'(locked), 32'd1);
            end
        end
        drive(1'b0, 4'b0000);
        check_outs("saturated", 3'(k), 1'b0, 1'b1, 1'b1, 1'b0, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the 4-stage Johnson counter. It samples a Johnson-coded bus and decodes each code to a binary phase index. It flags illegal codes and out-of-sequence steps, and keeps a lock indication that shows whether the incoming stream is a clean, advancing Johnson sequence. It sits downstream of any Johnson counter output, for example a shared phase bus or a cross-check on a local counter, and is used for phase recovery and fault monitoring.

## Interface
- WIDTH, 4: Johnson code width N. There are 2N legal codes. Must be ≥2.
- LOCK_COUNT, 3: consecutive correct successor steps required to enter LOCKED. Range 1..15.
- ERR_LIMIT, 2: consecutive bad samples in LOCKED that force a return to HUNT. Range 1..15.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- din_valid  in  1  qualifies din for this cycle.
- din  in  WIDTH  Johnson-coded input.
- idx  out  IW = clog2(2·WIDTH)  decoded phase index of the last legal sample.
- idx_valid  out  1  pulse: idx was updated from this cycle's registered sample.
- legal  out  1  registered legality of the last valid sample.
- locked  out  1  high while in the LOCKED state.
- seq_err  out  1  one-cycle pulse per bad sample while LOCKED.
- err_cnt  out  8  saturating count of seq_err pulses.

## Operation
- Legal code set, in sequence order for N=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000. These map to idx 0..7.
- Decoding, with p = popcount(din):
  - din[N-1]=0 gives k = p.
  - din[N-1]=1 gives k = 2N − p.
  - The sample is legal iff din equals the canonical code for k. The canonical code is the low k ones for k≤N, and the top 2N−k ones for k>N.
- A sample is processed only when din_valid=1. When din_valid=0, all state holds and seq_err and idx_valid are 0.
- Expected successor: (ref + 1) mod 2N. ref is the last legal idx. Wrap from 2N−1 to 0 is a correct step.
- A sample is "good" if it is legal and equals the expected successor. It is "bad" if it is illegal, or legal but not the successor. A repeated code counts as bad.
- State machine, with states HUNT and LOCKED:
  - **HUNT, legal sample:** ref ← k.
    - If the sample is good, run ← run+1.
    - Otherwise run ← 0, and the sample becomes the new reference.
    - When run reaches LOCK_COUNT, go to LOCKED with run ← 0 and bad ← 0.
  - **HUNT, illegal sample:** run ← 0 and ref is invalidated. The next legal sample only sets ref.
  - **LOCKED, good sample:** ref ← k, bad ← 0.
  - **LOCKED, bad sample:** seq_err=1, err_cnt+1 (saturating at 255), bad ← bad+1.
    - A legal bad sample still updates ref and idx.
    - When bad reaches ERR_LIMIT, go to HUNT with run ← 0.
- The first legal sample after reset or after an illegal sample only establishes ref. It never counts as a step.
- err_cnt counts only in LOCKED. It is cleared only by rst.
- Reset mid-operation: all state returns to reset values on that edge, and any in-flight sample is discarded.

## Timing
- All outputs are registered. Latency is 1 cycle: a sample at edge t is reflected in the outputs after edge t+1.
- Reset values: idx=0, idx_valid=0, legal=0, locked=0, seq_err=0, err_cnt=0, state HUNT, run=0, bad=0, ref invalid.
- idx_valid = registered (din_valid & legal). idx holds its value on illegal or invalid cycles.
- locked rises in the cycle after the LOCK_COUNT-th good step. It falls in the same output cycle as the seq_err pulse that reaches ERR_LIMIT.
- Full rate is supported: one sample per clock, back to back.

## Structure
- Shared package (johnson_pkg):
  - function for the canonical code of index k;
  - popcount function;
  - state enum {HUNT, LOCKED};
  - index-width localparam helper.
- One natural sub-module, johnson_code_decode: combinational din → k, legal. It is reusable by other Johnson-code consumers. The FSM, counters and output registers stay in johnson_decoder.

## Test plan
- **Reset and lock.** Assert rst for 2 cycles, then feed 0000, 0001, 0011, 0111 on consecutive valid cycles.
  - During reset: all outputs 0.
  - locked=1 after the 4th sample, given LOCK_COUNT=3.
  - idx reads 0,1,2,3.
- **Wrap.** While locked, feed 1100, 1000, 0000, 0001.
  - idx reads 6,7,0,1.
  - No seq_err; locked stays 1.
- **Illegal code.** While locked, inject 0101, then resume with the correct successor.
  - One seq_err pulse; err_cnt=1; idx unchanged; legal=0.
  - locked remains 1 because bad=1 < ERR_LIMIT.
- **Loss of lock.** While locked, feed a repeated 0011 twice.
  - Two seq_err pulses; err_cnt increments by 2.
  - locked=0 after the second repeat. Then 3 good steps are required to relock.
- **Gating and reset mid-run.** Drop din_valid with garbage on din for 5 cycles: no output change. Then assert rst while locked with err_cnt=3: all outputs return to 0 and the state is HUNT.
- **Saturation.** Force more than 255 bad samples with ERR_LIMIT raised or lock repeatedly re-acquired: err_cnt holds at 255.
